// File: rtl/peribus_pkg.sv
// Shared definitions for peripheral-bus blocks: timer register offsets,
// CTRL/STATUS bit positions and the packed CTRL layout.
package peribus_pkg;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_STATUS = 2'd1;
  localparam logic [1:0] TMR_RELOAD = 2'd2;
  localparam logic [1:0] TMR_COUNT  = 2'd3;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ONESHOT_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT  = 2;
  localparam int CTRL_PSC_LSB     = 4;

  localparam int STATUS_MATCH_BIT   = 0;
  localparam int STATUS_RUNNING_BIT = 1;

  typedef struct packed {
    logic [3:0] psc;
    logic       rsvd;
    logic       irq_en;
    logic       oneshot;
    logic       en;
  } ctrl_t;

  function automatic logic [15:0] ctrl_to_word(input ctrl_t c);
    return {8'h00, c.psc, 1'b0, c.irq_en, c.oneshot, c.en};
  endfunction

endpackage

// File: rtl/peribus_prescaler.sv
// Power-of-two prescaler: counts to 2^exp-1 and emits a one-cycle pre_tick.
module peribus_prescaler (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [3:0] i_exp,
  output logic       o_pre_tick
);

  logic [15:0] r_cnt;
  logic [15:0] w_mask;
  logic        w_terminal;

  assign w_mask     = ~(16'hFFFF << i_exp);
  assign w_terminal = (r_cnt == w_mask);
  assign o_pre_tick = i_enable & w_terminal;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= 16'h0000;
    end else if (i_clear) begin
      r_cnt <= 16'h0000;
    end else if (i_enable) begin
      r_cnt <= w_terminal ? 16'h0000 : r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/peribus_timer.sv
// 16-bit programmable timer on the peripheral bus: CTRL/STATUS/RELOAD/COUNT,
// power-of-two prescaler, level irq and a registered wrap tick for chaining.
module peribus_timer
  import peribus_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR  = 8'h00,
  parameter logic [15:0] RELOAD_RST = 16'hFFFF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [7:0]  i_addr,
  input  logic [15:0] i_write_data,
  input  logic        i_write_enable,
  input  logic        i_read_enable,
  output logic [15:0] o_read_data,
  output logic        o_irq,
  output logic        o_tick
);

  ctrl_t       r_ctrl;
  logic        r_match;
  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic        r_tick;

  logic [8:0]  w_diff;
  logic        w_in_range;
  logic [1:0]  w_off;
  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic        w_wr_reload;
  logic        w_wr_count;
  logic        w_pre_tick;
  logic        w_wrap;
  ctrl_t       w_ctrl_new;
  logic [15:0] w_status;
  logic [15:0] w_read_data;

  // 9-bit subtract so addresses below BASE_ADDR borrow out of range instead of aliasing
  assign w_diff     = {1'b0, i_addr} - {1'b0, BASE_ADDR};
  assign w_in_range = (w_diff < 9'd4);
  assign w_off      = w_diff[1:0];

  assign w_wr_ctrl   = i_write_enable && w_in_range && (w_off == TMR_CTRL);
  assign w_wr_status = i_write_enable && w_in_range && (w_off == TMR_STATUS);
  assign w_wr_reload = i_write_enable && w_in_range && (w_off == TMR_RELOAD);
  assign w_wr_count  = i_write_enable && w_in_range && (w_off == TMR_COUNT);

  assign w_ctrl_new.psc     = i_write_data[CTRL_PSC_LSB +: 4];
  assign w_ctrl_new.rsvd    = 1'b0;
  assign w_ctrl_new.irq_en  = i_write_data[CTRL_IRQ_EN_BIT];
  assign w_ctrl_new.oneshot = i_write_data[CTRL_ONESHOT_BIT];
  assign w_ctrl_new.en      = i_write_data[CTRL_EN_BIT];

  peribus_prescaler u_prescaler (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (~r_ctrl.en),
    .i_enable   (r_ctrl.en),
    .i_exp      (r_ctrl.psc),
    .o_pre_tick (w_pre_tick)
  );

  // A bus write to COUNT pre-empts the wrap: no tick, no match that cycle
  assign w_wrap = w_pre_tick && (r_count == r_reload) && !w_wr_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ctrl   <= '0;
      r_match  <= 1'b0;
      r_reload <= RELOAD_RST;
      r_count  <= 16'h0000;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= w_wrap;

      if (w_wr_ctrl) begin
        r_ctrl <= w_ctrl_new;
      end else if (w_wrap && r_ctrl.oneshot) begin
        r_ctrl.en <= 1'b0;
      end

      if (w_wrap) begin
        r_match <= 1'b1;
      end else if (w_wr_status && i_write_data[STATUS_MATCH_BIT]) begin
        r_match <= 1'b0;
      end

      if (w_wr_reload) begin
        r_reload <= i_write_data;
      end

      if (w_wr_count) begin
        r_count <= i_write_data;
      end else if (w_pre_tick) begin
        r_count <= (r_count == r_reload) ? 16'h0000 : r_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_status                     = 16'h0000;
    w_status[STATUS_MATCH_BIT]   = r_match;
    w_status[STATUS_RUNNING_BIT] = r_ctrl.en;
  end

  always_comb begin
    w_read_data = 16'h0000;
    if (i_read_enable && w_in_range) begin
      case (w_off)
        TMR_CTRL:   w_read_data = ctrl_to_word(r_ctrl);
        TMR_STATUS: w_read_data = w_status;
        TMR_RELOAD: w_read_data = r_reload;
        TMR_COUNT:  w_read_data = r_count;
        default:    w_read_data = 16'h0000;
      endcase
    end
  end

  assign o_read_data = w_read_data;
  assign o_irq       = r_match & r_ctrl.irq_en;
  assign o_tick      = r_tick;

endmodule

// File: tb/tb_peribus_timer.sv
// Scoreboard bench for peribus_timer: expected values are queued as stimulus
// is applied and popped as the DUT is sampled on the falling edge.
module tb_peribus_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr = 8'h00;
  logic [15:0] wd = 16'h0000;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] rd;
  logic        irq;
  logic        tick;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb_q[$];

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h01;
  localparam logic [7:0] A_RELOAD = 8'h02;
  localparam logic [7:0] A_COUNT  = 8'h03;

  peribus_timer #(.BASE_ADDR(8'h00), .RELOAD_RST(16'hFFFF)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_addr         (addr),
    .i_write_data   (wd),
    .i_write_enable (we),
    .i_read_enable  (re),
    .o_read_data    (rd),
    .o_irq          (irq),
    .o_tick         (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wd = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [15:0] d);
    addr = a; re = 1'b1;
    #1;
    d = rd;
    re = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    logic [31:0] exp;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(32'h0000); sb_q.push_back(32'h0000);
    sb_q.push_back(32'hFFFF); sb_q.push_back(32'h0000);
    sb_q.push_back(32'h0000);
    for (int a = 0; a < 5; a++) begin
      bus_read(8'(a), v);
      exp = sb_q.pop_front();
      n_checks++;
      if ({16'h0, v} !== exp) $display("FAIL reset_read addr %0d: got %h expected %h", a, v, exp[15:0]);
      else n_pass++;
    end
    n_checks++;
    if (irq !== 1'b0 || tick !== 1'b0) $display("FAIL reset_outputs: irq=%b tick=%b expected 0 0", irq, tick);
    else n_pass++;
    addr = A_RELOAD; re = 1'b0; #1;
    n_checks++;
    if (rd !== 16'h0000) $display("FAIL read_enable_low: got %h expected 0000", rd);
    else n_pass++;
    bus_write(8'h04, 16'h1234);
    bus_read(A_RELOAD, v);
    n_checks++;
    if (v !== 16'hFFFF) $display("FAIL out_of_range_write: RELOAD got %h expected FFFF", v);
    else n_pass++;
  endtask

  task automatic test_periodic();
    logic [15:0] c, s;
    logic [31:0] exp;
    bus_write(A_RELOAD, 16'd4);
    bus_write(A_CTRL, 16'h0005);
    for (int i = 0; i <= 10; i++)
      sb_q.push_back({14'h0, (i >= 5), (i > 0 && i % 5 == 0), 16'(i % 5)});
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      bus_read(A_COUNT, c);
      exp = sb_q.pop_front();
      n_checks++;
      if ({14'h0, irq, tick, c} !== exp) $display("FAIL periodic cycle %0d: irq/tick/count got %b/%b/%h expected %b/%b/%h", i, irq, tick, c, exp[17], exp[16], exp[15:0]);
      else n_pass++;
    end
    bus_read(A_STATUS, s);
    n_checks++;
    if (s !== 16'h0003) $display("FAIL periodic_status: got %h expected 0003", s);
    else n_pass++;
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_STATUS, 16'h0001);
    bus_write(A_COUNT, 16'h0000);
  endtask

  task automatic test_prescale_oneshot();
    logic [15:0] c, s;
    logic [31:0] exp;
    bus_write(A_RELOAD, 16'd2);
    bus_write(A_CTRL, 16'h0023);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] ec;
      ec = (i < 4) ? 16'd0 : (i < 8) ? 16'd1 : (i < 12) ? 16'd2 : 16'd0;
      sb_q.push_back({13'h0, (i >= 12) ? 2'b01 : 2'b10, (i == 12), ec});
    end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      bus_read(A_COUNT, c);
      bus_read(A_STATUS, s);
      exp = sb_q.pop_front();
      n_checks++;
      if ({13'h0, s[1:0], tick, c} !== exp) $display("FAIL prescale_oneshot cycle %0d: status/tick/count got %h/%b/%h expected %h/%b/%h", i, s[1:0], tick, c, exp[18:17], exp[16], exp[15:0]);
      else n_pass++;
    end
    bus_read(A_CTRL, c);
    n_checks++;
    if (c !== 16'h0022) $display("FAIL oneshot_ctrl: got %h expected 0022", c);
    else n_pass++;
  endtask

  task automatic test_w1c();
    logic [15:0] s;
    bus_write(A_CTRL, 16'h0004);
    #1;
    n_checks++;
    if (irq !== 1'b1) $display("FAIL irq_enable: irq got %b expected 1", irq);
    else n_pass++;
    bus_write(A_STATUS, 16'h0001);
    bus_read(A_STATUS, s);
    n_checks++;
    if (s !== 16'h0000 || irq !== 1'b0) $display("FAIL w1c_idle: status/irq got %h/%b expected 0000/0", s, irq);
    else n_pass++;
    bus_write(A_RELOAD, 16'd3);
    bus_write(A_CTRL, 16'h0005);
    repeat (2) @(negedge clk);
    bus_write(A_STATUS, 16'h0001);
    bus_read(A_STATUS, s);
    n_checks++;
    if (s !== 16'h0003 || irq !== 1'b1) $display("FAIL w1c_race: status/irq got %h/%b expected 0003/1", s, irq);
    else n_pass++;
    n_checks++;
    if (tick !== 1'b1) $display("FAIL w1c_race_tick: got %b expected 1", tick);
    else n_pass++;
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_STATUS, 16'h0001);
    bus_write(A_COUNT, 16'h0000);
    bus_read(A_STATUS, s);
    n_checks++;
    if (s !== 16'h0000) $display("FAIL w1c_cleanup: status got %h expected 0000", s);
    else n_pass++;
  endtask

  task automatic test_count_priority();
    logic [15:0] c, s;
    logic [31:0] exp;
    bus_write(A_CTRL, 16'h0001);
    repeat (3) @(negedge clk);
    bus_read(A_COUNT, c);
    n_checks++;
    if (c !== 16'd3) $display("FAIL count_pre_write: got %h expected 0003", c);
    else n_pass++;
    addr = A_COUNT; wd = 16'd3; we = 1'b1;
    sb_q.push_back({15'h0, 1'b0, 1'b0, 16'd3});
    sb_q.push_back({15'h0, 1'b1, 1'b1, 16'd0});
    sb_q.push_back({15'h0, 1'b1, 1'b0, 16'd1});
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      bus_read(A_COUNT, c);
      bus_read(A_STATUS, s);
      exp = sb_q.pop_front();
      n_checks++;
      if ({15'h0, s[0], tick, c} !== exp) $display("FAIL count_priority cycle %0d: match/tick/count got %b/%b/%h expected %b/%b/%h", i, s[0], tick, c, exp[17], exp[16], exp[15:0]);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] c;
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_COUNT, 16'd2);
    bus_write(A_CTRL, 16'h0004);
    bus_read(A_COUNT, c);
    n_checks++;
    if (c !== 16'd2 || irq !== 1'b1) $display("FAIL async_setup: count/irq got %h/%b expected 0002/1", c, irq);
    else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    addr = A_COUNT; re = 1'b1;
    #0.5;
    n_checks++;
    if (rd !== 16'h0000) $display("FAIL async_count: got %h expected 0000", rd);
    else n_pass++;
    n_checks++;
    if (irq !== 1'b0 || tick !== 1'b0) $display("FAIL async_outputs: irq/tick got %b/%b expected 0/0", irq, tick);
    else n_pass++;
    addr = A_RELOAD;
    #0.5;
    n_checks++;
    if (rd !== 16'hFFFF) $display("FAIL async_reload: got %h expected FFFF", rd);
    else n_pass++;
    re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_prescale_oneshot();
    test_w1c();
    test_count_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/peribus_timer.md
Name: peribus_timer

Overview:
- 16-bit programmable timer peripheral on the peripheral bus, downstream of the memory unit's peripheral window (CPU addresses 0x300–0x3FF).
- The memory unit's peripheral bus controller drives its 8-bit address, write data and strobes, and muxes its read data back.
- Its irq output feeds the controller's interrupt line, which the memory unit gates with the IRQ-enable register.

Parameters:
- BASE_ADDR, 8'h00, 8-bit peripheral offset of register 0; the block occupies BASE_ADDR..BASE_ADDR+3.
- RELOAD_RST, 16'hFFFF, reset value of RELOAD.

Ports:
- clock  in  1  peripheral bus clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- addr  in  8  peripheral word address.
- write_data  in  16  write data.
- write_enable  in  1  write strobe; level-sampled each rising edge.
- read_enable  in  1  read qualifier.
- read_data  out  16  combinational read data.
- irq  out  1  interrupt request, level.
- tick  out  1  one-cycle pulse on every counter wrap, for chaining.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 CTRL: [0] EN, [1] ONESHOT, [2] IRQ_EN, [7:4] PSC (divide by 2^PSC); other bits read 0.
  - 1 STATUS: [0] MATCH (write 1 to clear), [1] RUNNING (read-only, mirrors EN); other bits read 0.
  - 2 RELOAD: 16-bit period.
  - 3 COUNT: read returns the live count; a write loads the count.
- Register hit: write_enable=1 and addr in range. Out-of-range addresses are ignored; no wrap or alias.
- Writes are idempotent, so a strobe held for several cycles has the same effect as one cycle.
- Reset values: CTRL=0, MATCH=0, RELOAD=RELOAD_RST, COUNT=0, prescaler=0, irq=0, tick=0.
- read_data:
  - Equals the addressed register when read_enable=1 and addr is in range; otherwise 16'h0000.
  - Reads have no side effects.
- Prescaler:
  - 16-bit counter psc_cnt, cleared while EN=0.
  - pre_tick = EN & (psc_cnt == 2^PSC−1). On pre_tick psc_cnt←0, else psc_cnt+1.
  - PSC=0 gives pre_tick every cycle while enabled.
- Counter, on pre_tick:
  - If COUNT==RELOAD: COUNT←0, MATCH←1, tick=1 for that cycle, and if ONESHOT then EN←0.
  - Otherwise COUNT←COUNT+1.
  - RELOAD=0 sets MATCH on every pre_tick.
- Period = (RELOAD+1)·2^PSC cycles; first match occurs (RELOAD+1)·2^PSC cycles after EN rises from 0.
- tick is registered: high in the cycle after the wrap edge, exactly one cycle wide.
- irq = MATCH & IRQ_EN, driven from flops (no combinational path from the bus).
- Simultaneous events:
  - Write to COUNT in a pre_tick cycle: the write wins; the tick is dropped and MATCH is not set.
  - W1C to MATCH in the same cycle as a new match: set wins, MATCH stays 1.
  - CTRL write with EN=1 to a running timer: psc_cnt is not cleared.
  - CTRL write with EN going 0→1: psc_cnt and COUNT are unchanged.
  - ONESHOT clear of EN in the same cycle as a CTRL write: the CTRL write wins.
- RELOAD written below the current COUNT: the counter runs to 16'hFFFF, wraps to 0 without a match, then matches normally.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronous); irq and tick drop the same instant.

Decomposition:
- peribus_pkg holds:
  - Register offsets: TMR_CTRL=0, TMR_STATUS=1, TMR_RELOAD=2, TMR_COUNT=3.
  - CTRL and STATUS bit-position constants.
  - A packed struct typedef for CTRL.
- Sub-module peribus_prescaler: 16-bit counter with clear, enable and 4-bit exponent, producing pre_tick. Reusable by later peripherals such as a UART baud generator.

Test Plan:
- Reset check: after reset, read all four registers → CTRL=0, STATUS=0, RELOAD=16'hFFFF, COUNT=0; irq=0; out-of-range addr BASE_ADDR+4 reads 0.
- Periodic: RELOAD=4, CTRL=16'h0005 (EN, IRQ_EN, PSC=0) → MATCH/irq set 5 cycles after enable; tick pulses every 5 cycles; COUNT sequence 0,1,2,3,4,0.
- Prescale and oneshot: RELOAD=2, CTRL=16'h0023 (EN, ONESHOT, PSC=2) → match 12 cycles after enable; EN and RUNNING clear; COUNT stays 0; no further ticks.
- W1C race: write STATUS=1 in the same cycle a match occurs → MATCH remains 1. Write STATUS=1 on an idle cycle → MATCH=0, irq=0.
- COUNT write priority: RELOAD=3, running PSC=0, write COUNT=3 on the cycle COUNT would wrap → COUNT=3 next cycle, no tick; match occurs on the following cycle.
- Async reset mid-count: assert reset with COUNT=16'h0002 and irq=1 → COUNT=0 and irq=0 without waiting for a clock edge.
